wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning register and data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width (2^ADDR_W = 32 entries).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port we_i  input  1  write enable, driven by the MEM/WB wreg output.
REQ-006 SHALL have port waddr_i  input  ADDR_W  write address (rd).
REQ-007 SHALL have port wdata_i  input  DATA_W  write data.
REQ-008 SHALL have port re1_i  input  1  read enable, port 1.
REQ-009 SHALL have port raddr1_i  input  ADDR_W  read address, port 1 (rs1).
REQ-010 SHALL have port rdata1_o  output  DATA_W  read data, port 1.
REQ-011 SHALL have port re2_i  input  1  read enable, port 2.
REQ-012 SHALL have port raddr2_i  input  ADDR_W  read address, port 2 (rs2).
REQ-013 SHALL have port rdata2_o  output  DATA_W  read data, port 2.
REQ-014 SHALL have port dbg_addr_i  input  ADDR_W  debug/difftest read address.
REQ-015 SHALL have port dbg_data_o  output  DATA_W  debug read data (architectural, no bypass).
REQ-016 SHALL have port commit_valid_o  output  1  one-cycle pulse: a register write retired last cycle.
REQ-017 SHALL have port commit_addr_o  output  ADDR_W  address of last retired write.
REQ-018 SHALL have port commit_data_o  output  DATA_W  data of last retired write.
REQ-019 SHALL have port wr_count_o  output  64  count of retired register writes.

Function
REQ-020 An effective write SHALL be defined as we_i=1 and waddr_i!=0 with rst high at the rising edge.
REQ-021 On an effective write, entry[waddr_i] SHALL take wdata_i at that edge; no other entry SHALL change.
REQ-022 Entry 0 SHALL read as 0 always; writes to address 0 SHALL be discarded with no commit pulse and no count.
REQ-023 Read ports SHALL be combinational (zero latency) with priority: re=0 -> 0; raddr=0 -> 0; we_i=1 and waddr_i=raddr -> wdata_i (write-through bypass); else entry[raddr].
REQ-024 Both read ports SHALL bypass independently, including both addressing the write target in the same cycle.
REQ-025 dbg_data_o SHALL be combinational entry[dbg_addr_i], 0 for address 0, never bypassed (pre-edge value during a same-address write).
REQ-026 commit_valid_o SHALL be registered: high for exactly the one cycle following each effective write, low otherwise.
REQ-027 commit_addr_o/commit_data_o SHALL load waddr_i/wdata_i on each effective write and hold their value otherwise.
REQ-028 wr_count_o SHALL increment by 1 on each effective write, wrap from 2^64-1 to 0, and hold otherwise.
REQ-029 Back-to-back effective writes on consecutive cycles SHALL each produce a commit pulse (commit_valid_o stays high) and each increment the count.
REQ-030 Writes of identical data to the same address SHALL still be counted and committed.

Reset
REQ-031 While rst=0, all 32 entries, commit_valid_o, commit_addr_o, commit_data_o and wr_count_o SHALL be 0, asserted asynchronously without waiting for clk.
REQ-032 A write presented on the edge where rst=0 SHALL be ignored; reset asserted mid-sequence SHALL discard all prior state.
REQ-033 Read ports SHALL remain combinational during reset (returning 0, or wdata_i via bypass if we_i=1 and addresses match).

Verification
REQ-034 Reset release, then read all 32 addresses on both ports and dbg -> all 0; commit_valid_o=0; wr_count_o=0.
REQ-035 Write x5=0x1234_5678_9ABC_DEF0 with raddr1=raddr2=5 in same cycle -> both rdata = written value before the edge, dbg_data_o=0 before / value after; next cycle commit_valid_o=1, commit_addr_o=5, wr_count_o=1.
REQ-036 we_i=1, waddr_i=0, wdata_i=all-ones -> rdata (raddr=0)=0, no commit pulse, wr_count_o unchanged.
REQ-037 Writes x1..x31 on 31 consecutive cycles -> commit_valid_o high 31 cycles, wr_count_o=31, each register reads its value; re1_i=0 -> rdata1_o=0.
REQ-038 Assert rst low asynchronously between clock edges after writes -> all outputs and entries 0 immediately; write on the same edge ignored.
REQ-039 Force wr_count_o to 2^64-1 via preload/backdoor, one effective write -> wr_count_o=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Two-read, one-write register file with x0 hardwired to zero, write-through read bypass,
// a non-bypassed debug read port and a retired-write commit/count trace.
module wb_regfile #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic              commit_valid_o,
    output logic [ADDR_W-1:0] commit_addr_o,
    output logic [DATA_W-1:0] commit_data_o,
    output logic [63:0]       wr_count_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [63:0]       wr_count;
    logic              wr_en;

    assign wr_en      = we_i && (waddr_i != '0);
    assign wr_count_o = wr_count;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            commit_valid_o <= 1'b0;
            commit_addr_o  <= '0;
            commit_data_o  <= '0;
            wr_count       <= '0;
        end else begin
            commit_valid_o <= wr_en;
            if (wr_en) begin
                regs[waddr_i]  <= wdata_i;
                commit_addr_o  <= waddr_i;
                commit_data_o  <= wdata_i;
                wr_count       <= wr_count + 64'd1;
            end
        end
    end

    // Bypass does not look at rst, so a write presented during reset is still visible.
    function automatic logic [DATA_W-1:0] read_port(input logic re, input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (!re || addr == '0) begin
            val = '0;
        end else if (we_i && waddr_i == addr) begin
            val = wdata_i;
        end else begin
            val = regs[addr];
        end
        return val;
    endfunction

    always_comb begin
        rdata1_o   = read_port(re1_i, raddr1_i);
        rdata2_o   = read_port(re2_i, raddr2_i);
        dbg_data_o = (dbg_addr_i == '0) ? '0 : regs[dbg_addr_i];
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector table plus hand-written reset, burst-write and counter-wrap sequences for wb_regfile.
module tb_wb_regfile;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam logic [63:0] D5   = 64'h1234_5678_9ABC_DEF0;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic              clk;
    logic              rst;
    logic              we_i;
    logic [ADDR_W-1:0] waddr_i;
    logic [DATA_W-1:0] wdata_i;
    logic              re1_i;
    logic [ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0] rdata1_o;
    logic              re2_i;
    logic [ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0] rdata2_o;
    logic [ADDR_W-1:0] dbg_addr_i;
    logic [DATA_W-1:0] dbg_data_o;
    logic              commit_valid_o;
    logic [ADDR_W-1:0] commit_addr_o;
    logic [DATA_W-1:0] commit_data_o;
    logic [63:0]       wr_count_o;

    int errors;
    int checks;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              re1;
        logic [ADDR_W-1:0] raddr1;
        logic              re2;
        logic [ADDR_W-1:0] raddr2;
        logic [ADDR_W-1:0] dbg_addr;
        logic [DATA_W-1:0] exp_r1;
        logic [DATA_W-1:0] exp_r2;
        logic [DATA_W-1:0] exp_dbg;
        logic              exp_cv;
        logic [ADDR_W-1:0] exp_ca;
        logic [DATA_W-1:0] exp_cd;
        logic [63:0]       exp_cnt;
    } vec_t;

    vec_t vecs [9];

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .we_i           (we_i),
        .waddr_i        (waddr_i),
        .wdata_i        (wdata_i),
        .re1_i          (re1_i),
        .raddr1_i       (raddr1_i),
        .rdata1_o       (rdata1_o),
        .re2_i          (re2_i),
        .raddr2_i       (raddr2_i),
        .rdata2_o       (rdata2_o),
        .dbg_addr_i     (dbg_addr_i),
        .dbg_data_o     (dbg_data_o),
        .commit_valid_o (commit_valid_o),
        .commit_addr_o  (commit_addr_o),
        .commit_data_o  (commit_data_o),
        .wr_count_o     (wr_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        we_i       = v.we;
        waddr_i    = v.waddr;
        wdata_i    = v.wdata;
        re1_i      = v.re1;
        raddr1_i   = v.raddr1;
        re2_i      = v.re2;
        raddr2_i   = v.raddr2;
        dbg_addr_i = v.dbg_addr;
    endtask

    task automatic idleInputs();
        we_i = 1'b0; waddr_i = '0; wdata_i = '0;
        re1_i = 1'b0; raddr1_i = '0; re2_i = 1'b0; raddr2_i = '0; dbg_addr_i = '0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b0;
        idleInputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [63:0] burstVal(input int i);
        return {32'hC0DE_0000 | 32'(i), 32'(i * 7 + 3)};
    endfunction

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        idleInputs();

        // Table: {we,waddr,wdata,re1,raddr1,re2,raddr2,dbg, r1,r2,dbg, cv,ca,cd,cnt}
        vecs[0] = '{1'b1, 5'd5, D5,      1'b1, 5'd5, 1'b1, 5'd5, 5'd5, D5,     D5,     64'h0,  1'b0, 5'd0, 64'h0,  64'd0};
        vecs[1] = '{1'b0, 5'd0, 64'h0,   1'b1, 5'd5, 1'b1, 5'd0, 5'd5, D5,     64'h0,  D5,     1'b1, 5'd5, D5,     64'd1};
        vecs[2] = '{1'b1, 5'd0, ONES,    1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 64'h0,  64'h0,  64'h0,  1'b0, 5'd5, D5,     64'd1};
        vecs[3] = '{1'b0, 5'd0, 64'h0,   1'b1, 5'd0, 1'b1, 5'd5, 5'd0, 64'h0,  D5,     64'h0,  1'b0, 5'd5, D5,     64'd1};
        vecs[4] = '{1'b1, 5'd7, 64'hAA,  1'b0, 5'd7, 1'b1, 5'd7, 5'd7, 64'h0,  64'hAA, 64'h0,  1'b0, 5'd5, D5,     64'd1};
        vecs[5] = '{1'b1, 5'd7, 64'hAA,  1'b1, 5'd7, 1'b1, 5'd5, 5'd7, 64'hAA, D5,     64'hAA, 1'b1, 5'd7, 64'hAA, 64'd2};
        vecs[6] = '{1'b1, 5'd5, 64'h55,  1'b1, 5'd5, 1'b1, 5'd7, 5'd5, 64'h55, 64'hAA, D5,     1'b1, 5'd7, 64'hAA, 64'd3};
        vecs[7] = '{1'b0, 5'd0, 64'h0,   1'b1, 5'd5, 1'b1, 5'd7, 5'd5, 64'h55, 64'hAA, 64'h55, 1'b1, 5'd5, 64'h55, 64'd4};
        vecs[8] = '{1'b0, 5'd0, 64'h0,   1'b1, 5'd9, 1'b0, 5'd5, 5'd9, 64'h0,  64'h0,  64'h0,  1'b0, 5'd5, 64'h55, 64'd4};

        // Reset release: every entry reads zero on all three ports
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset_commit_valid", 64'(commit_valid_o), 64'd0);
        checkOutput("reset_wr_count", wr_count_o, 64'd0);
        re1_i = 1'b1;
        re2_i = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr1_i = 5'(a);
            raddr2_i = 5'(31 - a);
            dbg_addr_i = 5'(a);
            #1;
            checkOutput($sformatf("reset_rd1[%0d]", a), rdata1_o, 64'h0);
            checkOutput($sformatf("reset_rd2[%0d]", 31 - a), rdata2_o, 64'h0);
            checkOutput($sformatf("reset_dbg[%0d]", a), dbg_data_o, 64'h0);
        end

        // Vector table: inputs driven after negedge, all outputs sampled before the next posedge
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_rdata1", i), rdata1_o, vecs[i].exp_r1);
            checkOutput($sformatf("v%0d_rdata2", i), rdata2_o, vecs[i].exp_r2);
            checkOutput($sformatf("v%0d_dbg", i), dbg_data_o, vecs[i].exp_dbg);
            checkOutput($sformatf("v%0d_commit_valid", i), 64'(commit_valid_o), 64'(vecs[i].exp_cv));
            checkOutput($sformatf("v%0d_commit_addr", i), 64'(commit_addr_o), 64'(vecs[i].exp_ca));
            checkOutput($sformatf("v%0d_commit_data", i), commit_data_o, vecs[i].exp_cd);
            checkOutput($sformatf("v%0d_wr_count", i), wr_count_o, vecs[i].exp_cnt);
        end

        // Burst of 31 back-to-back writes after a clean reset
        doReset();
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we_i = 1'b1;
            waddr_i = 5'(i);
            wdata_i = burstVal(i);
            #1;
            checkOutput($sformatf("burst_cv[%0d]", i), 64'(commit_valid_o), (i > 1) ? 64'd1 : 64'd0);
            checkOutput($sformatf("burst_cnt[%0d]", i), wr_count_o, 64'(i - 1));
        end
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("burst_last_cv", 64'(commit_valid_o), 64'd1);
        checkOutput("burst_last_addr", 64'(commit_addr_o), 64'd31);
        checkOutput("burst_last_data", commit_data_o, burstVal(31));
        checkOutput("burst_wr_count", wr_count_o, 64'd31);
        @(negedge clk);
        checkOutput("burst_cv_drop", 64'(commit_valid_o), 64'd0);
        re1_i = 1'b1;
        re2_i = 1'b1;
        for (int i = 1; i < 32; i++) begin
            raddr1_i = 5'(i);
            raddr2_i = 5'(i);
            dbg_addr_i = 5'(i);
            #1;
            checkOutput($sformatf("burst_rd1[%0d]", i), rdata1_o, burstVal(i));
            checkOutput($sformatf("burst_dbg[%0d]", i), dbg_data_o, burstVal(i));
        end
        re1_i = 1'b0;
        raddr1_i = 5'd12;
        #1;
        checkOutput("burst_re1_off", rdata1_o, 64'h0);
        checkOutput("burst_re2_on", rdata2_o, burstVal(31));

        // Asynchronous reset between edges; a write presented during reset is only bypassed
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        dbg_addr_i = 5'd3;
        re1_i = 1'b1;
        raddr1_i = 5'd3;
        #1;
        checkOutput("areset_dbg3", dbg_data_o, 64'h0);
        checkOutput("areset_rd1", rdata1_o, 64'h0);
        checkOutput("areset_cnt", wr_count_o, 64'd0);
        checkOutput("areset_cv", 64'(commit_valid_o), 64'd0);
        checkOutput("areset_ca", 64'(commit_addr_o), 64'd0);
        checkOutput("areset_cd", commit_data_o, 64'h0);
        we_i = 1'b1;
        waddr_i = 5'd4;
        wdata_i = 64'hDEAD_BEEF_0000_0004;
        re2_i = 1'b1;
        raddr2_i = 5'd4;
        #1;
        checkOutput("areset_bypass", rdata2_o, 64'hDEAD_BEEF_0000_0004);
        @(negedge clk);
        idleInputs();
        rst = 1'b1;
        dbg_addr_i = 5'd4;
        #1;
        checkOutput("areset_write_ignored", dbg_data_o, 64'h0);
        checkOutput("areset_write_cnt", wr_count_o, 64'd0);
        checkOutput("areset_write_cv", 64'(commit_valid_o), 64'd0);

        // Counter wrap: preload the count to all ones, then one effective write
        @(negedge clk);
        force dut.wr_count = ONES;
        #1;
        release dut.wr_count;
        #1;
        checkOutput("wrap_preload", wr_count_o, ONES);
        we_i = 1'b1;
        waddr_i = 5'd2;
        wdata_i = 64'h2222;
        @(negedge clk);
        idleInputs();
        #1;
        checkOutput("wrap_count", wr_count_o, 64'd0);
        checkOutput("wrap_cv", 64'(commit_valid_o), 64'd1);
        @(negedge clk);
        checkOutput("wrap_hold", wr_count_o, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
